// File: rtl/clock_set_ctrl.sv
// User-interface sequencer for digital_clock: 1 Hz generation, set-mode FSM and step/seconds commands.
// Optional inactivity timeout in set modes is enabled by defining CLKSET_TIMEOUT_EN.
module clock_set_ctrl #(
    parameter int unsigned DIV       = 50_000_000,
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [5:0] sec_in,
    output logic       clk_1hz,
    output logic       time_pause,
    output logic       hour_inc,
    output logic       hour_dec,
    output logic       min_inc,
    output logic       min_dec,
    output logic [5:0] set_sec,
    output logic [1:0] mode
);

    localparam int unsigned CNT_W  = $clog2(DIV);
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned STEP_W = 4;
    localparam int unsigned TO_W   = 6;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);

    localparam logic [1:0] MODE_RUN = 2'd0;
    localparam logic [1:0] MODE_HR  = 2'd1;
    localparam logic [1:0] MODE_MIN = 2'd2;
    localparam logic [1:0] MODE_SEC = 2'd3;

    // Step vector bit order: {hour_inc, hour_dec, min_inc, min_dec}
    localparam logic [STEP_W-1:0] STEP_HR_INC  = 4'b1000;
    localparam logic [STEP_W-1:0] STEP_HR_DEC  = 4'b0100;
    localparam logic [STEP_W-1:0] STEP_MIN_INC = 4'b0010;
    localparam logic [STEP_W-1:0] STEP_MIN_DEC = 4'b0001;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clk_1hz_q, clk_1hz_d;
    logic              btn_mode_q, btn_up_q, btn_down_q;
    logic [1:0]        mode_q, mode_d;
    logic [STEP_W-1:0] pend_q, pend_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              time_pause_q, time_pause_d;
    logic [SEC_W-1:0]  set_sec_q, set_sec_d;
    logic [SEC_W-1:0]  sec_shadow_q, sec_shadow_d;

    logic              wrap, fall;
    logic              mode_p, up_p, down_p, step_acc;
    logic              to_fire, capture;
    logic [STEP_W-1:0] step_new;

`ifdef CLKSET_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_S);
    logic [TO_W-1:0] to_q, to_d;
    assign to_fire = (to_q == TO_LIMIT);
`else
    // Timer absent: TIMEOUT_S has no effect (its legal range excludes 0).
    assign to_fire = (TIMEOUT_S == 0);
`endif

    assign wrap     = (cnt_q == CNT_MAX);
    assign fall     = wrap & clk_1hz_q;
    assign mode_p   = btn_mode & ~btn_mode_q;
    assign up_p     = btn_up & ~btn_up_q;
    assign down_p   = btn_down & ~btn_down_q;
    assign step_acc = ~mode_p & (up_p ^ down_p);
    // Entering a set mode: reload the clock's own seconds so it stops without a jump.
    assign capture  = fall & (mode_q != MODE_RUN) & ~time_pause_q;

    always_comb begin
        step_new = '0;
        case (mode_q)
            MODE_HR:  step_new = up_p ? STEP_HR_INC : STEP_HR_DEC;
            MODE_MIN: step_new = up_p ? STEP_MIN_INC : STEP_MIN_DEC;
            default:  step_new = '0;
        endcase
    end

    always_comb begin
        cnt_d        = wrap ? '0 : cnt_q + CNT_W'(1);
        clk_1hz_d    = clk_1hz_q ^ wrap;
        mode_d       = mode_q;
        pend_d       = pend_q;
        step_d       = step_q;
        time_pause_d = time_pause_q;
        set_sec_d    = set_sec_q;
        sec_shadow_d = sec_shadow_q;

        if (to_fire) begin
            mode_d = MODE_RUN;
        end else if (mode_p) begin
            mode_d = mode_q + 2'd1;
        end

        // Output register set toward digital_clock only moves on FALL
        if (fall) begin
            time_pause_d = (mode_q != MODE_RUN);
            step_d       = pend_q;
            set_sec_d    = capture ? sec_in : sec_shadow_q;
        end

        if (mode_p || to_fire) begin
            pend_d = '0;
        end else if (step_acc && (pend_q == '0) && (step_new != '0)) begin
            pend_d = step_new;
        end else if (fall) begin
            pend_d = '0;
        end

        if (capture) begin
            sec_shadow_d = sec_in;
        end else if ((mode_q == MODE_SEC) && step_acc) begin
            if (up_p) begin
                sec_shadow_d = (sec_shadow_q == SEC_MAX) ? '0 : sec_shadow_q + SEC_W'(1);
            end else begin
                sec_shadow_d = (sec_shadow_q == '0) ? SEC_MAX : sec_shadow_q - SEC_W'(1);
            end
        end
    end

`ifdef CLKSET_TIMEOUT_EN
    always_comb begin
        to_d = to_q;
        if ((mode_q == MODE_RUN) || mode_p || step_acc || to_fire) begin
            to_d = '0;
        end else if (fall) begin
            to_d = to_q + TO_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            clk_1hz_q    <= 1'b0;
            btn_mode_q   <= 1'b0;
            btn_up_q     <= 1'b0;
            btn_down_q   <= 1'b0;
            mode_q       <= MODE_RUN;
            pend_q       <= '0;
            step_q       <= '0;
            time_pause_q <= 1'b0;
            set_sec_q    <= '0;
            sec_shadow_q <= '0;
`ifdef CLKSET_TIMEOUT_EN
            to_q         <= '0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            clk_1hz_q    <= clk_1hz_d;
            btn_mode_q   <= btn_mode;
            btn_up_q     <= btn_up;
            btn_down_q   <= btn_down;
            mode_q       <= mode_d;
            pend_q       <= pend_d;
            step_q       <= step_d;
            time_pause_q <= time_pause_d;
            set_sec_q    <= set_sec_d;
            sec_shadow_q <= sec_shadow_d;
`ifdef CLKSET_TIMEOUT_EN
            to_q         <= to_d;
`endif
        end
    end

    assign clk_1hz    = clk_1hz_q;
    assign time_pause = time_pause_q;
    assign hour_inc   = step_q[3];
    assign hour_dec   = step_q[2];
    assign min_inc    = step_q[1];
    assign min_dec    = step_q[0];
    assign set_sec    = set_sec_q;
    assign mode       = mode_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized and directed bench for clock_set_ctrl against a cycle-count based reference model.
module tb_clock_set_ctrl;

    localparam int DIV       = 4;
    localparam int TIMEOUT_S = 3;
    localparam int PERIOD    = 2 * DIV;
`ifdef CLKSET_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       btn_mode, btn_up, btn_down;
    logic [5:0] sec_in;
    logic       clk_1hz, time_pause, hour_inc, hour_dec, min_inc, min_dec;
    logic [5:0] set_sec;
    logic [1:0] mode;

    int n_checks;
    int n_errors;

    // Reference model state: k = rising edges since reset release
    int k;
    int m_mode, m_tp, m_set, m_shadow, m_to;
    int pend_field, pend_dir;
    int out_field, out_dir;
    int pbm, pbu, pbd;

    clock_set_ctrl #(.DIV(DIV), .TIMEOUT_S(TIMEOUT_S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .sec_in     (sec_in),
        .clk_1hz    (clk_1hz),
        .time_pause (time_pause),
        .hour_inc   (hour_inc),
        .hour_dec   (hour_dec),
        .min_inc    (min_inc),
        .min_dec    (min_dec),
        .set_sec    (set_sec),
        .mode       (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0; m_mode = 0; m_tp = 0; m_set = 0; m_shadow = 0; m_to = 0;
        pend_field = 0; pend_dir = 0; out_field = 0; out_dir = 0;
        pbm = 0; pbu = 0; pbd = 0;
    endtask

    // One rising edge of behaviour, from the rules: events, priorities, FALL transfers
    task automatic model_step();
        int  nk, dir, sin;
        bit  fall, mp, up, dn, acc, fire, cap;
        nk   = k + 1;
        fall = (nk % PERIOD) == 0;
        mp   = (btn_mode == 1'b1) && (pbm == 0);
        up   = (btn_up == 1'b1) && (pbu == 0);
        dn   = (btn_down == 1'b1) && (pbd == 0);
        acc  = !mp && (up != dn);
        dir  = up ? 1 : -1;
        fire = TO_EN && (m_to == TIMEOUT_S);
        sin  = int'(sec_in);
        cap  = fall && (m_mode != 0) && (m_tp == 0);

        if (fall) begin
            out_field = pend_field;
            out_dir   = pend_dir;
            m_set     = cap ? sin : m_shadow;
            m_tp      = (m_mode != 0) ? 1 : 0;
        end

        if (fire || mp) begin
            pend_dir = 0; pend_field = 0;
        end else if (acc && pend_dir == 0 && (m_mode == 1 || m_mode == 2)) begin
            pend_dir = dir; pend_field = m_mode;
        end else if (fall) begin
            pend_dir = 0; pend_field = 0;
        end

        if (cap) m_shadow = sin;
        else if (m_mode == 3 && acc) m_shadow = (m_shadow + dir + 60) % 60;

        if (m_mode == 0 || mp || acc || fire) m_to = 0;
        else if (fall) m_to = m_to + 1;

        if (fire) m_mode = 0;
        else if (mp) m_mode = (m_mode + 1) % 4;

        pbm = int'(btn_mode); pbu = int'(btn_up); pbd = int'(btn_down);
        k = nk;
    endtask

    task automatic compare_all();
        check("clk_1hz",    32'(clk_1hz),    32'((k / DIV) % 2));
        check("time_pause", 32'(time_pause), 32'(m_tp));
        check("hour_inc",   32'(hour_inc),   32'(out_field == 1 && out_dir == 1));
        check("hour_dec",   32'(hour_dec),   32'(out_field == 1 && out_dir == -1));
        check("min_inc",    32'(min_inc),    32'(out_field == 2 && out_dir == 1));
        check("min_dec",    32'(min_dec),    32'(out_field == 2 && out_dir == -1));
        check("set_sec",    32'(set_sec),    32'(m_set));
        check("mode",       32'(mode),       32'(m_mode));
    endtask

    // Called at a negedge: apply buttons, take one edge, compare, return at next negedge
    task automatic cyc(input logic bm, input logic bu, input logic bd);
        btn_mode = bm; btn_up = bu; btn_down = bd;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic press(input logic bm, input logic bu, input logic bd);
        cyc(bm, bu, bd);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_to_fall();
        int n;
        n = 0;
        do begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
        end while ((k % PERIOD) != 0 && n < 2 * PERIOD);
        check("fall_reached", 32'(k % PERIOD), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clk_1hz"}, 32'(clk_1hz), 32'd0);
        check({tag, "_pause"},   32'(time_pause), 32'd0);
        check({tag, "_steps"},   32'({hour_inc, hour_dec, min_inc, min_dec}), 32'd0);
        check({tag, "_set_sec"}, 32'(set_sec), 32'd0);
        check({tag, "_mode"},    32'(mode), 32'd0);
    endtask

    task automatic back_to_run();
        for (int i = 0; i < 4 && m_mode != 0; i++) press(1'b1, 1'b0, 1'b0);
        check("back_to_run", 32'(mode), 32'd0);
    endtask

    initial begin
        logic bm, bu, bd;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; sec_in = 6'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // Prescaler: rise after DIV edges, fall after 2*DIV
        for (int i = 1; i <= PERIOD; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (i == DIV) check("first_rise", 32'(clk_1hz), 32'd1);
            if (i == PERIOD) check("first_fall", 32'(clk_1hz), 32'd0);
        end

        // Enter SET_HR with seconds captured from the clock
        sec_in = 6'd37;
        cyc(1'b1, 1'b0, 1'b0);
        check("enter_hr_mode", 32'(mode), 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        run_to_fall();
        check("enter_pause", 32'(time_pause), 32'd1);
        check("enter_capture", 32'(set_sec), 32'd37);

        // SET_MIN: second press within one period is dropped
        press(1'b1, 1'b0, 1'b0);
        check("set_min_mode", 32'(mode), 32'd2);
        run_to_fall();
        press(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        run_to_fall();
        check("min_inc_on", 32'(min_inc), 32'd1);
        run_to_fall();
        check("min_inc_once", 32'(min_inc), 32'd0);
        press(1'b0, 1'b0, 1'b1);
        run_to_fall();
        check("min_dec_on", 32'(min_dec), 32'd1);
        check("hour_quiet", 32'({hour_inc, hour_dec}), 32'd0);
        run_to_fall();
        check("min_dec_off", 32'(min_dec), 32'd0);

        // SET_SEC: shadow arithmetic modulo 60
        press(1'b1, 1'b0, 1'b0);
        check("set_sec_mode", 32'(mode), 32'd3);
        for (int i = 0; i < 21; i++) press(1'b0, 1'b1, 1'b0);
        run_to_fall();
        check("shadow_58", 32'(set_sec), 32'd58);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0);
        run_to_fall();
        check("shadow_wrap_up", 32'(set_sec), 32'd1);
        press(1'b0, 1'b0, 1'b1);
        run_to_fall();
        check("shadow_0", 32'(set_sec), 32'd0);
        press(1'b0, 1'b0, 1'b1);
        run_to_fall();
        check("shadow_wrap_down", 32'(set_sec), 32'd59);

        // Simultaneous presses, then exit
        press(1'b0, 1'b1, 1'b1);
        run_to_fall();
        check("up_down_ignored", 32'(set_sec), 32'd59);
        press(1'b1, 1'b1, 1'b0);
        check("mode_wins", 32'(mode), 32'd0);
        run_to_fall();
        check("exit_pause", 32'(time_pause), 32'd0);
        check("exit_set_sec", 32'(set_sec), 32'd59);

        // Idle in SET_HR
        press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT_S; i++) run_to_fall();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("timeout_mode", 32'(mode), TO_EN ? 32'd0 : 32'd1);
        run_to_fall();
        check("timeout_pause", 32'(time_pause), TO_EN ? 32'd0 : 32'd1);
        back_to_run();
        run_to_fall();

        // Randomized button levels and seconds input
        bm = 1'b0; bu = 1'b0; bd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39, 0) == 0) bm = ~bm;
            if ($urandom_range(7, 0) == 0)  bu = ~bu;
            if ($urandom_range(7, 0) == 0)  bd = ~bd;
            if ($urandom_range(15, 0) == 0) sec_in = 6'($urandom_range(59, 0));
            cyc(bm, bu, bd);
        end
        cyc(1'b0, 1'b0, 1'b0);

        // Reset in the middle of a setting session
        back_to_run();
        press(1'b1, 1'b0, 1'b0);
        run_to_fall();
        check("pre_reset_pause", 32'(time_pause), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3 * PERIOD; i++) cyc(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
